pc_stack_unit: RTL
==================

Name: pc_stack_unit

Overview:
- Parametrised, synchronous successor to the CPU program counter. Holds the instruction address used to fetch from ROM.
- Supports stall, sequential increment, absolute jump, and subroutine call/return through an internal LIFO return stack.
- Sits between the controller, which issues pc_en/load_pc/call/ret, and the ROM address bus.

Parameters:
- AW, 13: program-counter and address width in bits.
- DEPTH, 4: return-stack entries; must be >= 1.
- RESET_ADDR, 0: pc_addr value after reset; AW bits.
- OW, 8: signed branch-offset width; used only with PC_REL_BRANCH_EN.

Ports:
- clk  input  1: system clock; all state updates on posedge.
- rst_n  input  1: asynchronous, active-low reset.
- pc_en  input  1: update enable. When low, all state holds and all commands are ignored.
- load_pc  input  1: absolute jump to ir_addr.
- call  input  1: push return address pc_addr+1, then jump to ir_addr.
- ret  input  1: pop the stack top into pc_addr.
- ir_addr  input  AW: jump/call target.
- pc_addr  output  AW: current instruction address (registered).
- stack_full  output  1: stack holds DEPTH entries (combinational from sp).
- stack_empty  output  1: stack holds 0 entries (combinational from sp).
- stack_err  output  1: sticky overflow/underflow flag (registered).
- depth  output  $clog2(DEPTH+1): current entry count.

Behaviour:
- Reset (async assert, synchronous release at next clk edge):
  - pc_addr=RESET_ADDR, sp=0, stack_err=0, so stack_empty=1, stack_full=0, depth=0.
  - Stack RAM contents are not cleared; reads never occur below sp.
- Reset mid-operation: in-flight call/ret is discarded; the reset values above apply immediately.
- Latency: a command sampled at edge N is visible on pc_addr after edge N. No combinational path from inputs to pc_addr.
- pc_en=0: pc_addr, sp, and stack contents hold; stack_err holds.
- pc_en=1: exactly one action per cycle, chosen by fixed priority ret > call > load_pc > (branch) > increment.
  - ret, sp>0: pc_addr<=stack[sp-1]; sp<=sp-1.
  - ret, sp==0 (underflow): pc_addr holds; stack_err<=1.
  - call, sp<DEPTH: stack[sp]<=pc_addr+1 (mod 2^AW); pc_addr<=ir_addr; sp<=sp+1.
  - call, sp==DEPTH (overflow): no push; pc_addr holds; stack_err<=1.
  - load_pc: pc_addr<=ir_addr; stack untouched.
  - increment: pc_addr<=pc_addr+1, truncated to AW bits, so 2^AW-1 wraps to 0.
- Arithmetic is unsigned modulo 2^AW. A call at pc_addr=2^AW-1 pushes 0.
- Simultaneous call+ret: ret wins; call is dropped with no error.
- Holding pc_addr on fault lets the controller's fault logic observe the faulting address. stack_err clears only on reset.
- Back-to-back call/ret on consecutive cycles is fully supported; there is no bubble.

Optional Feature:
- Macro: PC_REL_BRANCH_EN.
- Defined:
  - Adds ports branch (input, 1) and br_offset (input, OW, two's complement).
  - With pc_en=1, branch=1, and no higher-priority command: pc_addr<=pc_addr+sign_extend(br_offset) mod 2^AW.
  - Priority is below load_pc and above increment.
- Undefined: both ports are absent and the increment path is unchanged.

Decomposition:
- Package pc_pkg holds:
  - pc_cmd_e enum: PC_HOLD, PC_INC, PC_LOAD, PC_CALL, PC_RET, PC_BRANCH.
  - Default constants PC_AW=13, PC_DEPTH=4.
  - Function next_seq(pc) returning pc+1 mod 2^AW.
- Top level: a priority encoder decodes the inputs into pc_cmd_e, and a single always block updates pc_addr.
- Sub-module pc_return_stack (params AW, DEPTH):
  - Inputs: clk, rst_n, push, pop, wdata.
  - Outputs: rdata, full, empty, depth, err.
  - Owns sp and the RAM. Overflow/underflow detection lives there; the top-level stack_err is its sticky err output.

Test Plan:
- Reset then 5 cycles of pc_en=1 -> pc_addr 0,1,2,3,4,5. Pulsing rst_n low mid-count -> pc_addr=0 immediately, with no clk edge needed.
- pc_en=0 for 3 cycles with load_pc=1, ir_addr=0x100 -> pc_addr unchanged. Then pc_en=1 -> pc_addr=0x100.
- At pc_addr=0x010: call ir_addr=0x200, then call ir_addr=0x300 -> pc 0x300, depth=2. Then ret, ret -> pc 0x201 then 0x011, stack_empty=1.
- DEPTH=4, five nested calls -> 5th call leaves pc_addr held, stack_full=1, stack_err=1. Subsequently, ret on empty after draining keeps stack_err=1 and holds pc.
- AW=13, pc_addr=0x1FFF -> increment gives 0x0000. A call at 0x1FFF pushes 0x0000, and ret returns 0x0000.
- PC_REL_BRANCH_EN, OW=8:
  - pc 0x050 with br_offset=0xF0 (-16) -> 0x040.
  - branch with load_pc=1 and ir_addr=0x123 -> 0x123 (load wins).

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter / return-stack slice.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INC,
    PC_LOAD,
    PC_CALL,
    PC_RET,
    PC_BRANCH
  } pc_cmd_e;

  localparam int unsigned PC_AW     = 13;
  localparam int unsigned PC_DEPTH  = 4;
  localparam int unsigned PC_MAX_AW = 64;

  // Callers pass a zero-extended address and truncate the result back to AW bits.
  function automatic logic [PC_MAX_AW-1:0] next_seq(input logic [PC_MAX_AW-1:0] pc);
    return pc + PC_MAX_AW'(1);
  endfunction

endpackage

// File: rtl/pc_return_stack.sv
// LIFO of return addresses with sticky overflow/underflow flag; contents are never reset.
module pc_return_stack
  import pc_pkg::*;
#(
  parameter int unsigned AW    = PC_AW,
  parameter int unsigned DEPTH = PC_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [AW-1:0]              wdata,
  output logic [AW-1:0]              rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       err
);

  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] ram [DEPTH];
  logic [DW-1:0] sp;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;

  assign full   = (sp == DW'(DEPTH));
  assign empty  = (sp == '0);
  assign depth  = sp;
  assign wr_idx = IW'(sp);
  assign rd_idx = IW'(sp - DW'(1));
  assign rdata  = ram[rd_idx];

  // Pop outranks push so a stray simultaneous request behaves like a plain return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp  <= '0;
      err <= 1'b0;
    end else if (pop) begin
      if (empty) err <= 1'b1;
      else       sp  <= sp - DW'(1);
    end else if (push) begin
      if (full)  err <= 1'b1;
      else       sp  <= sp + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !pop && !full) ram[wr_idx] <= wdata;
  end

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with call/return stack. Define PC_REL_BRANCH_EN to add the
// signed relative-branch path (ports branch, br_offset; parameter OW).
module pc_stack_unit
  import pc_pkg::*;
#(
  parameter int unsigned AW         = PC_AW,
  parameter int unsigned DEPTH      = PC_DEPTH,
  parameter logic [AW-1:0] RESET_ADDR = '0
`ifdef PC_REL_BRANCH_EN
  ,
  parameter int unsigned OW         = 8
`endif
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pc_en,
  input  logic                       load_pc,
  input  logic                       call,
  input  logic                       ret,
`ifdef PC_REL_BRANCH_EN
  input  logic                       branch,
  input  logic [OW-1:0]              br_offset,
`endif
  input  logic [AW-1:0]              ir_addr,
  output logic [AW-1:0]              pc_addr,
  output logic                       stack_full,
  output logic                       stack_empty,
  output logic                       stack_err,
  output logic [$clog2(DEPTH+1)-1:0] depth
);

  pc_cmd_e       cmd;
  logic [AW-1:0] seq_addr;
  logic [AW-1:0] ret_addr;

  assign seq_addr = AW'(next_seq(PC_MAX_AW'(pc_addr)));

  always_comb begin
    cmd = PC_HOLD;
    if (pc_en) begin
      if (ret)          cmd = PC_RET;
      else if (call)    cmd = PC_CALL;
      else if (load_pc) cmd = PC_LOAD;
`ifdef PC_REL_BRANCH_EN
      else if (branch)  cmd = PC_BRANCH;
`endif
      else              cmd = PC_INC;
    end
  end

  pc_return_stack #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd == PC_CALL),
    .pop   (cmd == PC_RET),
    .wdata (seq_addr),
    .rdata (ret_addr),
    .full  (stack_full),
    .empty (stack_empty),
    .depth (depth),
    .err   (stack_err)
  );

  // Faulting call/ret leave pc_addr on the offending instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_addr <= RESET_ADDR;
    end else begin
      case (cmd)
        PC_INC:  pc_addr <= seq_addr;
        PC_LOAD: pc_addr <= ir_addr;
        PC_CALL: if (!stack_full)  pc_addr <= ir_addr;
        PC_RET:  if (!stack_empty) pc_addr <= ret_addr;
`ifdef PC_REL_BRANCH_EN
        PC_BRANCH: pc_addr <= pc_addr + AW'($signed(br_offset));
`endif
        default: ;
      endcase
    end
  end

endmodule
